finalproject_soc_pio_ctl: RTL and testbench
===========================================

FINALPROJECT_SOC_PIO_CTL -- requirements
Module: finalproject_soc_pio_ctl

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- WIDTH, 8, output port width in bits, legal range 1..32.
- RESET_VALUE, 0, value of the DATA register after reset, truncated to WIDTH bits.
- PULSE_CYCLES, 4, number of cycles a pulse is held, legal range 1..65535.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, the single clock.
- reset_n, input, 1, asynchronous active-low reset.
- address, input, 3, Avalon-MM word address.
- chipselect, input, 1, slave select.
- write_n, input, 1, active-low write strobe.
- writedata, input, 32, write data.
- readdata, output, 32, read data.
- out_port, output, WIDTH, registered output pins.

REQ-003 The block SHALL be an Avalon-MM slave with zero wait states and zero read latency; readdata SHALL be a combinational function of address and register state.

Function
REQ-004 A write SHALL occur on a rising clk edge when chipselect=1 and write_n=0; only writedata[WIDTH-1:0] SHALL be used.

REQ-005 The register map SHALL be:
- addr 0 DATA, R/W.
- addr 1 SET, W: write 1 sets the corresponding DATA bits.
- addr 2 CLR, W: write 1 clears the corresponding DATA bits.
- addr 3 PULSE, R/W: pulse mask.
- addr 4 STATUS, R: bit0 = busy, bits[31:16] = remaining pulse count.
- addr 5..7: reserved.

REQ-006 Reads of addr 0 and addr 3 SHALL return the register value zero-extended to 32 bits; reads of addr 1, 2 and 5..7 SHALL return 0.

REQ-007 Writes to read-only or reserved addresses SHALL be ignored.

REQ-008 A PULSE write SHALL load the pulse mask with writedata[WIDTH-1:0] and load the counter with PULSE_CYCLES on that edge.
- busy SHALL equal 1 while counter != 0.

REQ-009 While busy, the counter SHALL decrement by 1 per cycle.
- On the edge where the counter goes 1->0, the mask SHALL clear to 0.

REQ-010 out_port SHALL equal DATA | (busy ? mask : 0), driven from registered state only.
- A pulse SHALL assert its bits for exactly PULSE_CYCLES cycles, starting the cycle after the write edge.

REQ-011 A PULSE write while busy SHALL replace the mask and reload the counter.
- A PULSE write on the same edge as expiry SHALL win, i.e. reload.

REQ-012 A PULSE write with mask 0 SHALL still load the counter; busy SHALL be 1 and out_port SHALL be unaffected.

REQ-013 DATA, SET and CLR writes during a pulse SHALL update DATA immediately and SHALL NOT affect the counter or the mask.

REQ-014 The counter width SHALL be 16 bits; STATUS bits[31:16] SHALL show the counter value and bits[15:1] SHALL read 0.

Reset
REQ-015 reset_n=0 SHALL asynchronously force the following, regardless of clk:
- DATA = RESET_VALUE
- mask = 0
- counter = 0
- out_port = RESET_VALUE

REQ-016 Reset asserted mid-pulse SHALL terminate the pulse immediately; after release, out_port SHALL equal RESET_VALUE.

REQ-017 The first write SHALL be accepted on the first rising clk edge after reset_n deasserts.

Configuration
REQ-018 Macro PIO_PULSE_EN, when defined, SHALL compile in the PULSE register, the counter and STATUS per REQ-008..REQ-014.

REQ-019 Without PIO_PULSE_EN:
- addr 3 and addr 4 SHALL behave as reserved.
- out_port SHALL equal DATA.
- No counter logic SHALL be synthesised.

Verification
REQ-020 The bench SHALL cover, with WIDTH=8, RESET_VALUE=8'h05, PULSE_CYCLES=4:
- Reset -> out_port=8'h05, readdata at addr 0 = 32'h5, STATUS=0.
- Write DATA=0xFFFFFF3C -> out_port=8'h3C; SET 8'h81 -> 8'hBD; CLR 8'h0C -> 8'hB1.
- DATA=8'h00, PULSE write 8'h10 -> out_port=8'h10 for exactly 4 cycles, then 8'h00; STATUS bits[31:16] read 4, 3, 2, 1, 0.
- Rewrite PULSE 8'h02 while the counter = 2 -> out_port=8'h02 for 4 further cycles.
- Assert reset_n=0 with the counter = 3 -> out_port=8'h05 with no clk edge; STATUS=0 after release.
- Write addr 6 with 0xFF -> no state change, readdata=0.
- Build without PIO_PULSE_EN -> addr 3 write ignored, addr 3 reads 0.

Source files
------------

// File: rtl/finalproject_soc_pio_ctl.sv
// ---------------------------------------------------------------------------
// finalproject_soc_pio_ctl
//
// Purpose:
//   Avalon-MM parallel output port. It has zero wait states and zero read
//   latency. A DATA register drives the output pins. Software can change it
//   directly, or set and clear bits through write-one-to-set / clear aliases.
//   An optional pulse engine ORs a mask onto the pins for a fixed number of
//   cycles after each PULSE write.
//
// Register map (word addresses):
//   0 DATA   R/W
//   1 SET    W   (write 1 sets the corresponding DATA bits, reads 0)
//   2 CLR    W   (write 1 clears the corresponding DATA bits, reads 0)
//   3 PULSE  R/W pulse mask              (only with PIO_PULSE_EN)
//   4 STATUS R   bit0 busy, [31:16] count (only with PIO_PULSE_EN)
//   5..7     reserved (reads 0, writes ignored)
//
// Configuration macro:
//   PIO_PULSE_EN - when defined, builds the PULSE register, the 16-bit
//                  countdown and STATUS. When undefined, addresses 3 and 4
//                  are reserved and out_port equals DATA.
//
// Parameters:
//   WIDTH        output width, 1..32
//   RESET_VALUE  DATA value after reset, truncated to WIDTH bits
//   PULSE_CYCLES number of cycles a pulse is held, 1..65535
//
// Ports:
//   clk         single clock
//   reset_n     asynchronous active-low reset
//   address     word address [2:0]
//   chipselect  slave select
//   write_n     active-low write strobe
//   writedata   write data [31:0]; only [WIDTH-1:0] is used
//   readdata    combinational read data [31:0]
//   out_port    output pins [WIDTH-1:0], derived from registers only
// ---------------------------------------------------------------------------
module finalproject_soc_pio_ctl #(
    parameter int          WIDTH        = 8,
    parameter logic [31:0] RESET_VALUE  = 32'h0,
    parameter int          PULSE_CYCLES = 4
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    localparam logic [WIDTH-1:0] RESET_DATA = RESET_VALUE[WIDTH-1:0];

    localparam logic [2:0] ADDR_DATA   = 3'd0;
    localparam logic [2:0] ADDR_SET    = 3'd1;
    localparam logic [2:0] ADDR_CLR    = 3'd2;
`ifdef PIO_PULSE_EN
    localparam logic [2:0] ADDR_PULSE  = 3'd3;
    localparam logic [2:0] ADDR_STATUS = 3'd4;
    localparam logic [15:0] PULSE_LOAD = 16'(PULSE_CYCLES);
`endif

    logic             wr_en;
    logic [WIDTH-1:0] wr_bits;
    logic [WIDTH-1:0] data_reg;

    assign wr_en   = chipselect & ~write_n;
    assign wr_bits = writedata[WIDTH-1:0];

    // DATA register. SET and CLR are read-modify-write aliases of it. Any
    // other address leaves DATA alone, so pulse writes never disturb it.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            data_reg <= RESET_DATA;
        end else if (wr_en) begin
            case (address)
                ADDR_DATA: data_reg <= wr_bits;
                ADDR_SET:  data_reg <= data_reg | wr_bits;
                ADDR_CLR:  data_reg <= data_reg & ~wr_bits;
                default:   data_reg <= data_reg;
            endcase
        end
    end

`ifdef PIO_PULSE_EN
    logic [WIDTH-1:0] mask_reg;
    logic [15:0]      count_reg;
    logic             busy;

    assign busy = (count_reg != 16'd0);

    // Pulse engine. A PULSE write reloads both mask and counter, and it takes
    // priority over the countdown. As a result, a write on the expiry edge
    // restarts the pulse instead of ending it. The mask is cleared on the 1->0
    // edge so that STATUS and the PULSE readback both return to zero together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            mask_reg  <= '0;
            count_reg <= 16'd0;
        end else if (wr_en && address == ADDR_PULSE) begin
            mask_reg  <= wr_bits;
            count_reg <= PULSE_LOAD;
        end else if (busy) begin
            count_reg <= count_reg - 16'd1;
            if (count_reg == 16'd1) begin
                mask_reg <= '0;
            end
        end
    end

    // The pins depend only on registers, so reset reaches them without a
    // clock edge.
    assign out_port = data_reg | (busy ? mask_reg : '0);

    // Zero-latency read mux.
    always_comb begin
        readdata = 32'h0;
        case (address)
            ADDR_DATA:   readdata = 32'(data_reg);
            ADDR_PULSE:  readdata = 32'(mask_reg);
            ADDR_STATUS: readdata = {count_reg, 15'h0, busy};
            default:     readdata = 32'h0;
        endcase
    end
`else
    assign out_port = data_reg;

    // Zero-latency read mux. Only DATA is readable in this build.
    always_comb begin
        readdata = 32'h0;
        if (address == ADDR_DATA) begin
            readdata = 32'(data_reg);
        end
    end
`endif

endmodule

// File: tb/tb_finalproject_soc_pio_ctl.sv
// ---------------------------------------------------------------------------
// tb_finalproject_soc_pio_ctl
//
// Self-checking bench for finalproject_soc_pio_ctl. The bench uses WIDTH=8,
// RESET_VALUE=8'h05 and PULSE_CYCLES=4.
//
// Stimulus pushes hand-computed expectations into a queue. A monitor on the
// falling clock edge pops each entry and compares it against readdata and
// out_port. Pulse-engine vectors are built only when PIO_PULSE_EN is defined.
// In the other build, the bench instead checks that addresses 3 and 4 behave
// as reserved.
// ---------------------------------------------------------------------------
module tb_finalproject_soc_pio_ctl;

    logic        clk;
    logic        reset_n;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    typedef struct {
        string       name;
        logic [31:0] exp_read;
        logic [7:0]  exp_out;
    } exp_t;

    exp_t exp_q[$];
    int   checks   = 0;
    int   failures = 0;

    finalproject_soc_pio_ctl #(
        .WIDTH        (8),
        .RESET_VALUE  (32'h05),
        .PULSE_CYCLES (4)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .address    (address),
        .chipselect (chipselect),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (readdata),
        .out_port   (out_port)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Monitor: on each falling edge, consume every pending expectation and
    // compare it against the outputs the DUT is presenting.
    always @(negedge clk) begin : monitor
        exp_t e;
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checks++;
            if (readdata !== e.exp_read) begin
                failures++;
                $display("[TB] FAIL %s readdata: got %h expected %h", e.name, readdata, e.exp_read);
            end
            checks++;
            if (out_port !== e.exp_out) begin
                failures++;
                $display("[TB] FAIL %s out_port: got %h expected %h", e.name, out_port, e.exp_out);
            end
        end
    end

    // Drive one bus write. The caller is just past an edge, so the write lands
    // on the next rising edge. The task returns 1 time unit after that edge.
    task automatic applyStimulus(input logic [2:0] addr, input logic [31:0] data);
        address    = addr;
        writedata  = data;
        chipselect = 1'b1;
        write_n    = 1'b0;
        @(posedge clk);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;
    endtask

    // Select a read address and queue the expected outputs. The monitor
    // compares them on the next falling edge. Each call uses one cycle.
    task automatic checkOutput(input string name, input logic [2:0] addr,
                               input logic [31:0] exp_read, input logic [7:0] exp_out);
        exp_t e;
        address    = addr;
        chipselect = 1'b0;
        write_n    = 1'b1;
        e.name     = name;
        e.exp_read = exp_read;
        e.exp_out  = exp_out;
        exp_q.push_back(e);
        @(negedge clk);
        #1;
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("[TB] FAIL %s monitor timeout: pending %0d expected 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Watchdog so the run always terminates.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time exceeded");
        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures + 1);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        reset_n    = 1'b0;
        address    = 3'd0;
        chipselect = 1'b0;
        write_n    = 1'b1;
        writedata  = 32'h0;

        // Values while reset is held.
        checkOutput("reset_data",   3'd0, 32'h0000_0005, 8'h05);
        checkOutput("reset_status", 3'd4, 32'h0000_0000, 8'h05);
        reset_n = 1'b1;

        // DATA write takes effect on the first edge after release. Upper
        // writedata bits are dropped. SET and CLR then modify DATA.
        applyStimulus(3'd0, 32'hFFFF_FF3C);
        checkOutput("data_wr",  3'd0, 32'h0000_003C, 8'h3C);
        applyStimulus(3'd1, 32'h0000_0081);
        checkOutput("set_wr",   3'd0, 32'h0000_00BD, 8'hBD);
        applyStimulus(3'd2, 32'h0000_000C);
        checkOutput("clr_wr",   3'd0, 32'h0000_00B1, 8'hB1);
        checkOutput("set_read", 3'd1, 32'h0000_0000, 8'hB1);
        checkOutput("clr_read", 3'd2, 32'h0000_0000, 8'hB1);

        // A write to a reserved address is ignored.
        applyStimulus(3'd6, 32'h0000_00FF);
        checkOutput("rsv6_read", 3'd6, 32'h0000_0000, 8'hB1);
        checkOutput("rsv6_data", 3'd0, 32'h0000_00B1, 8'hB1);

`ifdef PIO_PULSE_EN
        // Single pulse: 0x10 for four cycles while STATUS counts 4..1, then 0.
        applyStimulus(3'd0, 32'h0000_0000);
        checkOutput("data_zero", 3'd0, 32'h0000_0000, 8'h00);
        applyStimulus(3'd3, 32'h0000_0010);
        checkOutput("pulse_c4",  3'd4, 32'h0004_0001, 8'h10);
        checkOutput("pulse_c3",  3'd4, 32'h0003_0001, 8'h10);
        checkOutput("pulse_c2",  3'd4, 32'h0002_0001, 8'h10);
        checkOutput("pulse_c1",  3'd4, 32'h0001_0001, 8'h10);
        checkOutput("pulse_c0",  3'd4, 32'h0000_0000, 8'h00);
        checkOutput("mask_clr",  3'd3, 32'h0000_0000, 8'h00);

        // Retrigger with counter = 2: new mask held for four more cycles.
        applyStimulus(3'd3, 32'h0000_0010);
        checkOutput("re_c4",    3'd4, 32'h0004_0001, 8'h10);
        checkOutput("re_c3",    3'd4, 32'h0003_0001, 8'h10);
        checkOutput("re_c2",    3'd4, 32'h0002_0001, 8'h10);
        applyStimulus(3'd3, 32'h0000_0002);
        checkOutput("re2_c4",   3'd4, 32'h0004_0001, 8'h02);
        checkOutput("re2_mask", 3'd3, 32'h0000_0002, 8'h02);
        checkOutput("re2_c2",   3'd4, 32'h0002_0001, 8'h02);
        checkOutput("re2_c1",   3'd4, 32'h0001_0001, 8'h02);
        checkOutput("re2_c0",   3'd4, 32'h0000_0000, 8'h00);

        // Zero mask still runs the counter. A SET during the pulse updates
        // DATA at once and leaves the counter running.
        applyStimulus(3'd3, 32'h0000_0000);
        checkOutput("zmask_c4", 3'd4, 32'h0004_0001, 8'h00);
        applyStimulus(3'd1, 32'h0000_0022);
        checkOutput("set_mid",  3'd4, 32'h0003_0001, 8'h22);

        // Start a fresh pulse, then reset mid-pulse while the counter is 3.
        applyStimulus(3'd3, 32'h0000_0010);
        checkOutput("rp_c4",    3'd4, 32'h0004_0001, 8'h32);
        @(posedge clk);
        #1;
`else
        // Addresses 3 and 4 are reserved in this build.
        applyStimulus(3'd3, 32'h0000_00FF);
        checkOutput("nop_rd3",  3'd3, 32'h0000_0000, 8'hB1);
        applyStimulus(3'd4, 32'h0000_00FF);
        checkOutput("nop_rd4",  3'd4, 32'h0000_0000, 8'hB1);
        checkOutput("nop_data", 3'd0, 32'h0000_00B1, 8'hB1);
        applyStimulus(3'd0, 32'h0000_00A0);
        checkOutput("nop_wr",   3'd0, 32'h0000_00A0, 8'hA0);
`endif

        // Asynchronous reset. It is asserted just after a rising edge and
        // sampled on the following falling edge, so no rising edge occurs in
        // between.
        reset_n = 1'b0;
        checkOutput("rst_async",  3'd0, 32'h0000_0005, 8'h05);
        checkOutput("rst_status", 3'd4, 32'h0000_0000, 8'h05);
        reset_n = 1'b1;
        checkOutput("rel_status", 3'd4, 32'h0000_0000, 8'h05);
        checkOutput("rel_pulse",  3'd3, 32'h0000_0000, 8'h05);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
        $finish;
    end

endmodule
